seg_scan_decoder: RTL

- Receive-side counterpart of the single-digit seven-segment driver: monitors the multiplexed anode, segment and dp lines of an 8-digit active-low display.
- Reconstructs the hex value and decimal point of every digit and presents a complete frame with a one-cycle valid strobe.
- Used as a bus monitor in self-checking display benches and as a loop-back checker on the FPGA.

---
 rtl/seg_scan_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 8-digit active-low seven-segment display:
// debounces the scan pins, decodes each digit and emits whole frames with valid/error strobes.
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              seg,
   input  logic                    dp,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dps,
   output logic                    frame_valid,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int WW = NUM_DIGITS + 8;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {WAIT_START, COLLECT, DONE} state_t;

   logic [WW-1:0]           syncA_q, syncB_q, prevWord_q;
   logic [CW-1:0]           stableCnt_q;
   state_t                  state_q;
   logic [3:0]              nibBuf_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   dpBuf_q, seen_q, dps_q;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic                    frameValid_q, frameErr_q, busy_q;

   logic                  captureEv, anyLow, oneHot, segOk, isGood, isAbort;
   logic [NUM_DIGITS-1:0] lowMask, seenNext;
   logic [6:0]            lit;
   logic [3:0]            nibble;
   logic [IW-1:0]         digitIdx;

   // prevWord_q is the synchronized word one cycle older; the counter only grows while they agree
   always_ff @(posedge clk) begin
      if (rst) begin
         syncA_q     <= '1;
         syncB_q     <= '1;
         prevWord_q  <= '1;
         stableCnt_q <= '0;
      end else begin
         syncA_q    <= {an, seg, dp};
         syncB_q    <= syncA_q;
         prevWord_q <= syncB_q;
         if (syncB_q != prevWord_q)
            stableCnt_q <= '0;
         else if (stableCnt_q != CNT_MAX)
            stableCnt_q <= stableCnt_q + CW'(1);
      end
   end

   always_comb begin
      captureEv = (syncB_q == prevWord_q) && (stableCnt_q == CNT_CAP);
      lowMask   = ~prevWord_q[WW-1:8];
      lit       = ~prevWord_q[7:1];
      anyLow    = |lowMask;
      oneHot    = anyLow && ((lowMask & (lowMask - NUM_DIGITS'(1))) == '0);
      digitIdx  = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (lowMask[i]) digitIdx = IW'(i);
      segOk  = 1'b1;
      nibble = 4'h0;
      case (lit)
         7'h7E: nibble = 4'h0;
         7'h30: nibble = 4'h1;
         7'h6D: nibble = 4'h2;
         7'h79: nibble = 4'h3;
         7'h33: nibble = 4'h4;
         7'h5B: nibble = 4'h5;
         7'h5F: nibble = 4'h6;
         7'h70: nibble = 4'h7;
         7'h7F: nibble = 4'h8;
         7'h7B: nibble = 4'h9;
         7'h77: nibble = 4'hA;
         7'h1F: nibble = 4'hB;
         7'h4E: nibble = 4'hC;
         7'h3D: nibble = 4'hD;
         7'h4F: nibble = 4'hE;
         7'h47: nibble = 4'hF;
         default: segOk = 1'b0;
      endcase
      isGood   = oneHot && segOk;
      isAbort  = anyLow && !isGood;
      seenNext = seen_q | (NUM_DIGITS'(1) << digitIdx);
   end

   // Frame FSM; a digit-0 capture always (re)starts a frame, blanking never disturbs it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT_START;
         seen_q       <= '0;
         dpBuf_q      <= '0;
         digits_q     <= '0;
         dps_q        <= '0;
         frameValid_q <= 1'b0;
         frameErr_q   <= 1'b0;
         busy_q       <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) nibBuf_q[i] <= 4'h0;
      end else begin
         frameValid_q <= 1'b0;
         frameErr_q   <= 1'b0;
         case (state_q)
            WAIT_START: begin
               if (captureEv && isGood && digitIdx == '0) begin
                  nibBuf_q[0] <= nibble;
                  dpBuf_q[0]  <= ~prevWord_q[0];
                  seen_q      <= NUM_DIGITS'(1);
                  if (NUM_DIGITS == 1) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= COLLECT;
                     busy_q  <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (captureEv && isAbort) begin
                  frameErr_q <= 1'b1;
                  seen_q     <= '0;
                  state_q    <= WAIT_START;
                  busy_q     <= 1'b0;
               end else if (captureEv && isGood) begin
                  nibBuf_q[digitIdx] <= nibble;
                  dpBuf_q[digitIdx]  <= ~prevWord_q[0];
                  if (digitIdx == '0) begin
                     frameErr_q <= 1'b1;
                     seen_q     <= NUM_DIGITS'(1);
                  end else begin
                     seen_q <= seenNext;
                     if (seenNext == '1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
            end
            DONE: begin
               for (int i = 0; i < NUM_DIGITS; i++) digits_q[4*i +: 4] <= nibBuf_q[i];
               dps_q        <= dpBuf_q;
               frameValid_q <= 1'b1;
               seen_q       <= '0;
               state_q      <= WAIT_START;
            end
            default: state_q <= WAIT_START;
         endcase
      end
   end

   assign digits      = digits_q;
   assign dps         = dps_q;
   assign frame_valid = frameValid_q;
   assign frame_err   = frameErr_q;
   assign busy        = busy_q;

endmodule
